ym3438_slot_sequencer: RTL and testbench
========================================

YM3438_SLOT_SEQUENCER -- requirements
Module: ym3438_slot_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 6, meaning MCLK cycles per internal phase period; legal values are even integers 2..16.
REQ-002 The block SHALL have port MCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port sync_req, input, 1 bit: request to restart the slot sequence at slot 0.
REQ-005 The block SHALL have port stall, input, 1 bit: freezes sequencing; present only when YM3438_SEQ_STALL_EN is defined.
REQ-006 The block SHALL have port c1, output, 1 bit: phase-1 enable for the shift-register and latch primitives.
REQ-007 The block SHALL have port c2, output, 1 bit: phase-2 enable for the same primitives.
REQ-008 The block SHALL have port slot, output, 5 bits: current operator slot, 0..23.
REQ-009 The block SHALL have port channel, output, 3 bits: slot mod 6.
REQ-010 The block SHALL have port op, output, 2 bits: slot div 6.
REQ-011 The block SHALL have port sync, output, 1 bit: high while slot==23.
REQ-012 The block SHALL have port frame_cnt, output, 10 bits: count of completed 24-slot frames.

Function
REQ-013 The block SHALL keep a prescaler pcnt over 0..DIV-1 that increments by one per MCLK and wraps from DIV-1 to 0.
REQ-014 c1 and c2 SHALL be registered: c1 high exactly during the MCLK cycle where pcnt==0, and c2 high exactly where pcnt==DIV/2.
REQ-015 c1 and c2 SHALL never be high in the same cycle; each SHALL be one MCLK wide, with period DIV.
REQ-016 slot SHALL update only at the edge ending a c2-high cycle, becoming (slot+1) mod 24, so one slot spans exactly one c1 and one c2.
REQ-017 channel, op and sync SHALL be decoded from registered slot without extra latency.
REQ-018 A sync_req sampled high at an edge SHALL set a pending flag; at the next slot-update edge (including the same edge), slot SHALL load 0 and the pending flag SHALL clear.
REQ-019 frame_cnt SHALL increment by 1, mod 1024, at every slot update from 23 to 0, whether natural or coinciding with a pending sync.
REQ-020 A sync-forced restart from any slot other than 23 SHALL NOT increment frame_cnt.
REQ-021 Multiple sync_req pulses before one slot-update edge SHALL produce a single restart.

Reset
REQ-022 Asserting reset SHALL immediately set pcnt=DIV-1, c1=0, c2=0, slot=0, pending=0 and frame_cnt=0, so that channel=0, op=0 and sync=0.
REQ-023 The first c1 SHALL occur in the first MCLK cycle after the first rising edge following reset deassertion.
REQ-024 Reset asserted mid-slot SHALL abandon the slot, with no partial c1 or c2 pulse produced after the reset edge.

Configuration
REQ-025 With YM3438_SEQ_STALL_EN defined, stall high sampled at an edge SHALL hold pcnt, slot, pending and frame_cnt, and SHALL force c1=c2=0 for the next cycle.
REQ-026 On stall release, sequencing SHALL resume from the held pcnt with no pulse lost or duplicated.
REQ-027 While stall is high, sync_req SHALL still set pending.
REQ-028 Without YM3438_SEQ_STALL_EN, the stall port SHALL be absent and behaviour SHALL equal stall tied low.

Verification
REQ-029 Release reset with DIV=6 -> c1 at cycles 1, 7, 13…; c2 at cycles 4, 10, 16…; never overlapping.
REQ-030 Run 144 MCLK -> slot steps 0..23 once; sync high for the last 6 cycles; frame_cnt goes 0->1 on wrap.
REQ-031 Pulse sync_req for 1 cycle at slot 9 pcnt 1 -> slot becomes 0 after that slot's c2; frame_cnt unchanged.
REQ-032 Pulse sync_req during slot 23 -> slot becomes 0 and frame_cnt increments exactly once.
REQ-033 Assert reset at slot 15 pcnt 4 -> all outputs zero immediately; after release, the sequence restarts per REQ-029.
REQ-034 With YM3438_SEQ_STALL_EN, stall for 10 cycles at slot 5 pcnt 2 -> no c1/c2 pulses; after release, the next c2 arrives 1 cycle later; slot continues 5->6.

Source files
------------

// File: rtl/ym3438_slot_sequencer.sv
// rtl/ym3438_slot_sequencer.sv - YM3438 c1/c2 phase generator and 24-slot operator sequencer
// Optional stall input enabled by defining YM3438_SEQ_STALL_EN.
module ym3438_slot_sequencer #(
    parameter int DIV = 6
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       sync_req,
`ifdef YM3438_SEQ_STALL_EN
    input  logic       stall,
`endif
    output logic       c1,
    output logic       c2,
    output logic [4:0] slot,
    output logic [2:0] channel,
    output logic [1:0] op,
    output logic       sync,
    output logic [9:0] frame_cnt
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
    localparam logic [4:0] LAST_SLOT = 5'd23;

    logic          run;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nx;
    logic          pending;
    logic          pend_eff;
    logic          slot_upd;
    logic [4:0]    slot_nx;

`ifdef YM3438_SEQ_STALL_EN
    assign run = ~stall;
`else
    assign run = 1'b1;
`endif

    // A slot advances on the edge that closes its c2 cycle; a pending or same-edge sync_req forces slot 0.
    always_comb begin
        pcnt_nx  = (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
        pend_eff = pending | sync_req;
        slot_upd = run && (pcnt == P_HALF);
        slot_nx  = (pend_eff || slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            pcnt      <= P_LAST;
            c1        <= 1'b0;
            c2        <= 1'b0;
            slot      <= 5'd0;
            pending   <= 1'b0;
            frame_cnt <= 10'd0;
        end else begin
            pending <= slot_upd ? 1'b0 : pend_eff;
            if (run) begin
                pcnt <= pcnt_nx;
                c1   <= (pcnt_nx == '0);
                c2   <= (pcnt_nx == P_HALF);
            end else begin
                c1 <= 1'b0;
                c2 <= 1'b0;
            end
            if (slot_upd) begin
                slot <= slot_nx;
                if (slot == LAST_SLOT)
                    frame_cnt <= frame_cnt + 10'd1;
            end
        end
    end

    assign channel = 3'(slot % 5'd6);
    assign op      = 2'(slot / 5'd6);
    assign sync    = (slot == LAST_SLOT);

endmodule

// File: tb/tb_ym3438_slot_sequencer.sv
// tb/tb_ym3438_slot_sequencer.sv - self-checking bench for ym3438_slot_sequencer
module tb_ym3438_slot_sequencer;

    localparam int DIV = 6;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       sync_req = 1'b0;
    logic       stall = 1'b0;
    logic       c1;
    logic       c2;
    logic [4:0] slot;
    logic [2:0] channel;
    logic [1:0] op;
    logic       sync;
    logic [9:0] frame_cnt;

    ym3438_slot_sequencer #(.DIV(DIV)) dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .sync_req  (sync_req),
`ifdef YM3438_SEQ_STALL_EN
        .stall     (stall),
`endif
        .c1        (c1),
        .c2        (c2),
        .slot      (slot),
        .channel   (channel),
        .op        (op),
        .sync      (sync),
        .frame_cnt (frame_cnt)
    );

    always #5 MCLK = ~MCLK;

    int cmp_n = 0;
    int err_n = 0;
    bit chk_on = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge MCLK or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: phase follows the number of non-stalled edges since reset.
    int m_ticks = 0;
    int m_slot  = 0;
    int m_frame = 0;
    bit m_pend  = 1'b0;
    bit m_run   = 1'b0;
    int m_before;
    bit m_req;

    always @(posedge MCLK or posedge reset) begin
        if (reset) begin
            m_ticks = 0;
            m_slot  = 0;
            m_frame = 0;
            m_pend  = 1'b0;
            m_run   = 1'b0;
        end else begin
            m_req = m_pend || sync_req;
            m_run = !stall;
            if (m_run) begin
                m_before = (m_ticks + DIV - 1) % DIV;
                if (m_before == DIV / 2) begin
                    if (m_slot == 23) m_frame = (m_frame + 1) % 1024;
                    m_slot = m_req ? 0 : (m_slot + 1) % 24;
                    m_pend = 1'b0;
                end else begin
                    m_pend = m_req;
                end
                m_ticks++;
            end else begin
                m_pend = m_req;
            end
        end
    end

    always @(negedge MCLK) begin
        if (chk_on) begin
            int ph;
            ph = (m_ticks + DIV - 1) % DIV;
            check("c1", c1, int'(m_run && ph == 0));
            check("c2", c2, int'(m_run && ph == DIV / 2));
            check("c1_c2_overlap", int'(c1 && c2), 0);
            check("slot", slot, m_slot);
            check("channel", channel, m_slot % 6);
            check("op", op, m_slot / 6);
            check("sync", sync, int'(m_slot == 23));
            check("frame_cnt", frame_cnt, m_frame);
        end
    end

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge MCLK);
            guard++;
        end
        check("goto_cyc", cyc, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_c1"}, c1, 0);
        check({tag, "_c2"}, c2, 0);
        check({tag, "_slot"}, slot, 0);
        check({tag, "_channel"}, channel, 0);
        check({tag, "_op"}, op, 0);
        check({tag, "_sync"}, sync, 0);
        check({tag, "_frame"}, frame_cnt, 0);
    endtask

    task automatic pulse_check(input string tag);
        for (int i = 1; i <= 18; i++) begin
            goto(i);
            check({tag, "_c1_lit"}, c1, int'(i == 1 || i == 7 || i == 13));
            check({tag, "_c2_lit"}, c2, int'(i == 4 || i == 10 || i == 16));
        end
    endtask

    initial begin
        repeat (2) @(negedge MCLK);
        chk_on = 1'b1;
        check_zero("rst0");
        reset = 1'b0;
        pulse_check("boot");

        goto(136); check("slot22_lit", slot, 22);
        goto(142); check("slot23_lit", slot, 23); check("sync_lit", sync, 1); check("frame0_lit", frame_cnt, 0);
        goto(143); check("wrap_slot_lit", slot, 0); check("frame1_lit", frame_cnt, 1);

        goto(200); check("slot9_lit", slot, 9);
        sync_req = 1'b1;
        goto(201); sync_req = 1'b0;
        goto(202); check("slot9_hold_lit", slot, 9);
        goto(203); check("sync9_slot_lit", slot, 0); check("sync9_frame_lit", frame_cnt, 1);

        goto(343); check("slot23b_lit", slot, 23);
        sync_req = 1'b1;
        goto(344); sync_req = 1'b0;
        goto(347); check("sync23_slot_lit", slot, 0); check("sync23_frame_lit", frame_cnt, 2);
        goto(353); check("sync23_next_lit", slot, 1); check("sync23_once_lit", frame_cnt, 2);

        goto(359); check("slot2_lit", slot, 2);
        sync_req = 1'b1;
        goto(360); sync_req = 1'b0;
        goto(361); sync_req = 1'b1;
        goto(362); sync_req = 1'b0;
        goto(365); check("multi_slot_lit", slot, 0);
        goto(371); check("multi_single_lit", slot, 1);

        goto(455); check("slot15_lit", slot, 15);
        #1 reset = 1'b1;
        #1 check_zero("rst_mid");
        repeat (3) @(negedge MCLK);
        check_zero("rst_hold");
        reset = 1'b0;
        pulse_check("reboot");

`ifdef YM3438_SEQ_STALL_EN
        goto(33); check("stall_slot5_lit", slot, 5);
        stall = 1'b1;
        for (int i = 34; i <= 43; i++) begin
            goto(i);
            check("stall_c1_lit", c1, 0);
            check("stall_c2_lit", c2, 0);
        end
        stall = 1'b0;
        goto(44); check("resume_c2_lit", c2, 1); check("resume_slot5_lit", slot, 5);
        goto(45); check("resume_slot6_lit", slot, 6);
`endif

        goto(cyc + 30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
